i2c_burst_reader: RTL and testbench
===================================

I2C_BURST_READER -- requirements
Module: i2c_burst_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning system clocks per SCL quarter-period (50 MHz -> 100 kHz SCL).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h48, meaning the 7-bit I2C slave address.
REQ-003 SHALL have parameter START_REG, default 8'h00, meaning the sensor register pointer written before the burst read.
REQ-004 SHALL have port clk, input, 1, the system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, a synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request for a transaction; ignored while busy=1.
REQ-007 SHALL have port scl_oe, output, 1; 1 pulls SCL low, 0 releases SCL.
REQ-008 SHALL have port scl_in, input, 1, the sampled SCL line (external 2-FF synchronizer).
REQ-009 SHALL have port sda_oe, output, 1; 1 pulls SDA low, 0 releases SDA.
REQ-010 SHALL have port sda_in, input, 1, the sampled SDA line (external 2-FF synchronizer).
REQ-011 SHALL have ports byte0, byte1, byte2, byte3, output, 8 each, the bytes read in bus order.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at transaction end.
REQ-013 SHALL have port nack_err, output, 1, valid with done; 1 means the address or pointer byte was NACKed.
REQ-014 SHALL have port busy, output, 1, which is 1 from the cycle after an accepted start until the cycle done pulses.

Function
REQ-015 SHALL generate a phase tick every CLK_DIV clocks using a wrapping counter that is cleared on accepting start.
REQ-016 SHALL give each SCL bit four ticks, in order: SCL low/SDA setup, SCL release, sample SDA mid-high, SCL low.
REQ-017 SHALL run the sequence START, DEV_ADDR+W, ACK, START_REG, ACK, repeated START, DEV_ADDR+R, ACK, 4 read bytes, STOP.
REQ-018 SHALL use the states IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_ACK and STOP.
REQ-019 SHALL shift bytes MSB first, with an 8-bit shift register and a 3-bit bit counter that wraps 7->0 into the ACK state.
REQ-020 SHALL fail the ACK phase in TX_ACK when sda_in=1 at the sample tick: the FSM goes to STOP, sets nack_err=1, and leaves byte0..3 unchanged.
REQ-021 SHALL have the master drive ACK (sda_oe=1) after read bytes 0-2 and NACK (sda_oe=0) after byte 3.
REQ-022 SHALL update byte0..3 together, in the same cycle, only at a successful STOP; partial reads are never visible.
REQ-023 SHALL form START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-024 SHALL assert done for exactly one cycle after the STOP hold tick, then return to IDLE with busy=0.
REQ-025 SHALL ignore a start coincident with done; a new start is accepted only in IDLE.
REQ-026 SHALL hold nack_err until the next accepted start, which clears it.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, set state=IDLE, scl_oe=0, sda_oe=0, byte0..3=8'h00, done=0, nack_err=0, busy=0, and clear all counters.
REQ-028 SHALL allow reset mid-transaction; it releases both lines within one cycle and needs no STOP on the bus.

Configuration
REQ-029 SHALL support macro I2C_CLK_STRETCH_EN.
REQ-030 SHALL, when I2C_CLK_STRETCH_EN is defined, hold the tick counter after SCL release until scl_in=1 (slave clock stretching).
REQ-031 SHALL, when I2C_CLK_STRETCH_EN is undefined, ignore scl_in and advance phases on ticks only.

Verification
REQ-032 SHALL pass this scenario: slave model at 7'h48 returns 12 34 56 78 and start is pulsed -> byte0..3=12,34,56,78, done pulses once, nack_err=0, and the bus shows 90 00 Sr 91.
REQ-033 SHALL pass this scenario: no slave present (SDA always released) -> NACK on the address byte, STOP issued, nack_err=1, and byte0..3 keep their prior values.
REQ-034 SHALL pass this scenario: rst_n low during byte 2 -> next cycle scl_oe=sda_oe=0, busy=0, bytes=00; a following start completes normally.
REQ-035 SHALL pass this scenario: start pulsed while busy and again on the done cycle -> both are ignored, giving exactly one transaction.
REQ-036 SHALL pass this scenario: with I2C_CLK_STRETCH_EN defined, the slave holds SCL low for 500 clocks after the ACK -> the transfer stalls and then completes with correct data.
REQ-037 SHALL pass this scenario: CLK_DIV=4 -> each SCL period is 16 clocks and the total transaction length matches the computed bit count.

Source files
------------

// File: rtl/i2c_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_burst_reader
//  Function : I2C master. Writes a register pointer, then burst-reads 4 bytes
//             after a repeated START. Optional macro I2C_CLK_STRETCH_EN
//             enables slave clock stretching.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_burst_reader #(
    parameter int         CLK_DIV   = 125,
    parameter logic [6:0] DEV_ADDR  = 7'h48,
    parameter logic [7:0] START_REG = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic [7:0] byte0,
    output logic [7:0] byte1,
    output logic [7:0] byte2,
    output logic [7:0] byte3,
    output logic       done,
    output logic       nack_err,
    output logic       busy
);

    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        TX_BYTE = 4'd2,
        TX_ACK  = 4'd3,
        RSTART  = 4'd4,
        RX_BYTE = 4'd5,
        RX_ACK  = 4'd6,
        STOP    = 4'd7
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_phase;
    logic [2:0]         r_bit;
    logic [1:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx [4];
    logic               w_hold;
    logic               w_tick;
    logic               w_accept;

`ifdef I2C_CLK_STRETCH_EN
    // Phase 2 is the window after SCL release; a slave holding SCL low freezes it.
    assign w_hold = (r_phase == 2'd2) && !scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_in;
    assign w_hold       = 1'b0;
`endif

    assign w_tick   = (r_div == c_DIV_MAX) && !w_hold;
    assign w_accept = (r_state == IDLE) && start && !done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_accept) begin
            r_div <= '0;
        end else if (!w_hold) begin
            r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_phase  <= 2'd0;
            r_bit    <= 3'd0;
            r_idx    <= 2'd0;
            r_shift  <= 8'h00;
            r_rx     <= '{default: 8'h00};
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            byte0    <= 8'h00;
            byte1    <= 8'h00;
            byte2    <= 8'h00;
            byte3    <= 8'h00;
            done     <= 1'b0;
            nack_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_state  <= START;
                r_phase  <= 2'd0;
                r_bit    <= 3'd0;
                r_idx    <= 2'd0;
                r_shift  <= {DEV_ADDR, 1'b0};
                nack_err <= 1'b0;
                busy     <= 1'b1;
            end else if (r_state != IDLE && w_tick) begin
                r_phase <= r_phase + 2'd1;
                case (r_state)
                    // START and repeated START share one shape: SDA falls mid-high.
                    START, RSTART: begin
                        case (r_phase)
                            2'd0:    sda_oe <= 1'b0;
                            2'd1:    scl_oe <= 1'b0;
                            2'd2:    sda_oe <= 1'b1;
                            default: begin
                                scl_oe  <= 1'b1;
                                r_state <= TX_BYTE;
                            end
                        endcase
                    end
                    TX_BYTE: begin
                        case (r_phase)
                            2'd0:    sda_oe <= !r_shift[7];
                            2'd1:    scl_oe <= 1'b0;
                            2'd2:    ;
                            default: begin
                                scl_oe  <= 1'b1;
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_bit   <= r_bit + 3'd1;
                                if (r_bit == 3'd7) r_state <= TX_ACK;
                            end
                        endcase
                    end
                    TX_ACK: begin
                        case (r_phase)
                            2'd0:    sda_oe <= 1'b0;
                            2'd1:    scl_oe <= 1'b0;
                            2'd2:    if (sda_in) nack_err <= 1'b1;
                            default: begin
                                scl_oe <= 1'b1;
                                if (nack_err) begin
                                    r_state <= STOP;
                                end else begin
                                    case (r_idx)
                                        2'd0: begin
                                            r_shift <= START_REG;
                                            r_idx   <= 2'd1;
                                            r_state <= TX_BYTE;
                                        end
                                        2'd1: begin
                                            r_shift <= {DEV_ADDR, 1'b1};
                                            r_idx   <= 2'd2;
                                            r_state <= RSTART;
                                        end
                                        default: begin
                                            r_idx   <= 2'd0;
                                            r_state <= RX_BYTE;
                                        end
                                    endcase
                                end
                            end
                        endcase
                    end
                    RX_BYTE: begin
                        case (r_phase)
                            2'd0:    sda_oe  <= 1'b0;
                            2'd1:    scl_oe  <= 1'b0;
                            2'd2:    r_shift <= {r_shift[6:0], sda_in};
                            default: begin
                                scl_oe <= 1'b1;
                                r_bit  <= r_bit + 3'd1;
                                if (r_bit == 3'd7) r_state <= RX_ACK;
                            end
                        endcase
                    end
                    RX_ACK: begin
                        case (r_phase)
                            2'd0: begin
                                sda_oe       <= (r_idx != 2'd3);
                                r_rx[r_idx]  <= r_shift;
                            end
                            2'd1:    scl_oe <= 1'b0;
                            2'd2:    ;
                            default: begin
                                scl_oe <= 1'b1;
                                if (r_idx == 2'd3) begin
                                    r_state <= STOP;
                                end else begin
                                    r_idx   <= r_idx + 2'd1;
                                    r_state <= RX_BYTE;
                                end
                            end
                        endcase
                    end
                    STOP: begin
                        case (r_phase)
                            2'd0:    sda_oe <= 1'b1;
                            2'd1:    scl_oe <= 1'b0;
                            2'd2:    sda_oe <= 1'b0;
                            default: begin
                                r_state <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                // Results become visible all at once, never after a NACK.
                                if (!nack_err) begin
                                    byte0 <= r_rx[0];
                                    byte1 <= r_rx[1];
                                    byte2 <= r_rx[2];
                                    byte3 <= r_rx[3];
                                end
                            end
                        endcase
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_burst_reader
//  Function : Self-checking bench: I2C slave model on a wired-AND bus plus a
//             transaction-level timing/result model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_burst_reader;

    localparam int CLK_DIV    = 4;
    localparam int TICKS_FULL = 264;   // 4 START + 3x36 TX + 4 RSTART... see frame sum below
    localparam int TICKS_NACK = 44;    // START + address frame + STOP
    localparam int EV_S   = -1;
    localparam int EV_SR  = -2;
    localparam int EV_P   = -3;
    localparam int EV_ACK = -4;
    localparam int EV_NAK = -5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       scl_oe, sda_oe, scl_in, sda_in, done, nack_err, busy;
    logic [7:0] byte0, byte1, byte2, byte3;
    logic       s_scl_hold = 1'b0;
    logic       s_sda_low  = 1'b0;

    assign scl_in = ~scl_oe & ~s_scl_hold;
    assign sda_in = ~sda_oe & ~s_sda_low;

    always #5 clk = ~clk;

    i2c_burst_reader #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h48),
        .START_REG(8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .scl_oe  (scl_oe),
        .scl_in  (scl_in),
        .sda_oe  (sda_oe),
        .sda_in  (sda_in),
        .byte0   (byte0),
        .byte1   (byte1),
        .byte2   (byte2),
        .byte3   (byte3),
        .done    (done),
        .nack_err(nack_err),
        .busy    (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model (acts on the wired-AND bus lines) ----------
    logic       s_present = 1'b1;
    logic       s_stretch = 1'b0;
    logic [7:0] s_data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic       ps = 1'b1, pd = 1'b1;
    logic       s_active = 1'b0, s_tx = 1'b0, s_is_addr = 1'b0, s_sel = 1'b0;
    logic       s_rd = 1'b0, s_mack = 1'b0, s_stretch_done = 1'b0;
    int         s_bit = 0, s_k = 0, s_hold = 0;
    logic [7:0] s_shift = 8'h00;
    int         log_q[$];
    int         exp_q[$];
    int         rise_cyc[$];

    always @(negedge clk) begin
        logic scl, sda;
        scl = scl_in;
        sda = sda_in;
        if (!rst_n) begin
            s_active = 1'b0; s_tx = 1'b0; s_sel = 1'b0; s_bit = 0; s_k = 0;
            s_hold = 0; s_sda_low = 1'b0; s_scl_hold = 1'b0;
        end else begin
            if (ps && scl && pd && !sda) begin
                log_q.push_back(s_active ? EV_SR : EV_S);
                s_active = 1'b1; s_bit = 0; s_is_addr = 1'b1; s_tx = 1'b0; s_sda_low = 1'b0;
            end else if (ps && scl && !pd && sda) begin
                log_q.push_back(EV_P);
                s_active = 1'b0; s_tx = 1'b0; s_sda_low = 1'b0;
            end else if (s_active && !ps && scl) begin
                rise_cyc.push_back(cyc);
                if (s_bit < 8) begin
                    if (!s_tx) s_shift = {s_shift[6:0], sda};
                    s_bit++;
                    if (s_bit == 8 && !s_tx) begin
                        log_q.push_back(int'(s_shift));
                        if (s_is_addr) begin
                            s_sel = s_present && (s_shift[7:1] == 7'h48);
                            s_rd  = s_shift[0];
                        end
                    end
                end else if (s_bit == 8) begin
                    if (s_tx) begin
                        s_mack = !sda;
                        log_q.push_back(sda ? EV_NAK : EV_ACK);
                    end
                    s_bit = 9;
                end
            end else if (s_active && ps && !scl) begin
                if (s_bit == 8) begin
                    s_sda_low = !s_tx && s_sel;
                end else if (s_bit == 9) begin
                    s_bit = 0;
                    s_sda_low = 1'b0;
                    if (s_stretch && !s_stretch_done) begin
                        s_hold = 500;
                        s_stretch_done = 1'b1;
                    end
                    if (!s_tx && s_is_addr && s_sel && s_rd) begin
                        s_tx = 1'b1; s_k = 0;
                    end else if (s_tx && s_mack && s_k < 3) begin
                        s_k++;
                    end else begin
                        s_tx = 1'b0;
                    end
                    s_is_addr = 1'b0;
                    if (s_tx) s_sda_low = !s_data[s_k][7];
                end else if (s_tx && s_bit >= 1 && s_bit <= 7) begin
                    s_sda_low = !s_data[s_k][7 - s_bit];
                end
            end
            if (s_hold > 0) s_hold--;
            s_scl_hold = (s_hold > 0);
        end
        ps = scl;
        pd = sda;
    end

    // ---------------- transaction-level model ----------------
    // A full transfer is 66 bit-frames of 4 ticks: START, 3 TX frames of 9 bits,
    // RSTART, 4 RX frames of 9 bits, STOP; a NACKed address stops after frame 1.
    logic       m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0, m_will_nack = 1'b0;
    logic       m_check_en = 1'b1;
    logic [7:0] m_bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] m_pend  [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         m_end = 0;

    always @(posedge clk) begin
        logic prev_done;
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
            m_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
        end else begin
            prev_done = m_done;
            m_done = 1'b0;
            if (m_busy) begin
                if (cyc == m_end) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_nack = m_will_nack;
                    if (!m_will_nack) m_bytes = m_pend;
                end
            end else if (start && !prev_done) begin
                m_busy      = 1'b1;
                m_nack      = 1'b0;
                m_will_nack = !s_present;
                m_pend      = s_data;
                m_end       = cyc + (s_present ? TICKS_FULL : TICKS_NACK) * CLK_DIV;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_check_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("bytes", {byte0, byte1, byte2, byte3},
                  {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
            if (!m_busy) begin
                check("nack_err", 32'(nack_err), 32'(m_nack));
                check("lines_idle", 32'({scl_oe, sda_oe}), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(output int t_acc);
        start = 1'b1;
        t_acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int t);
        int n;
        n = 0;
        t = -1;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end else begin
            t = cyc;
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check(name, log_q[i], exp_q[i]);
    endtask

    initial begin
        int t_acc, t_done, n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lines", 32'({scl_oe, sda_oe}), 32'd0);
        check("rst_flags", 32'({busy, done, nack_err}), 32'd0);
        check("rst_bytes", {byte0, byte1, byte2, byte3}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: normal burst, with an ignored start mid-transfer and on the done cycle
        s_present = 1'b1;
        s_data = '{8'h12, 8'h34, 8'h56, 8'h78};
        log_q.delete(); rise_cyc.delete(); done_cnt = 0;
        pulse_start(t_acc);
        repeat (100) @(negedge clk);
        pulse_start(n);
        wait_done(2000, t_done);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("t1_len", t_done - t_acc, 32'd1056);
        check("t1_bytes", {byte0, byte1, byte2, byte3}, 32'h12345678);
        check("t1_nack", 32'(nack_err), 32'd0);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_scl_period", rise_cyc[2] - rise_cyc[1], 32'd16);
        exp_q = {EV_S, 32'h90, 32'h00, EV_SR, 32'h91, EV_ACK, EV_ACK, EV_ACK, EV_NAK, EV_P};
        check_log("t1_bus");

        // T2: nobody answers the address
        s_present = 1'b0;
        log_q.delete(); done_cnt = 0;
        pulse_start(t_acc);
        wait_done(2000, t_done);
        repeat (20) @(negedge clk);
        check("t2_len", t_done - t_acc, 32'd176);
        check("t2_nack", 32'(nack_err), 32'd1);
        check("t2_bytes", {byte0, byte1, byte2, byte3}, 32'h12345678);
        check("t2_done_cnt", done_cnt, 32'd1);
        exp_q = {EV_S, 32'h90, EV_P};
        check_log("t2_bus");

        // T3: reset while the third read byte is on the bus
        s_present = 1'b1;
        s_data = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        pulse_start(t_acc);
        n = 0;
        while (!(s_tx && s_k == 2 && s_bit == 3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t3_reached_byte2", 32'(s_tx && s_k == 2), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t3_rst_lines", 32'({scl_oe, sda_oe}), 32'd0);
        check("t3_rst_busy", 32'(busy), 32'd0);
        check("t3_rst_bytes", {byte0, byte1, byte2, byte3}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // T4: clean transfer after the mid-transfer reset
        s_data = '{8'hCA, 8'hFE, 8'hBE, 8'hEF};
        log_q.delete();
        pulse_start(t_acc);
        wait_done(2000, t_done);
        repeat (10) @(negedge clk);
        check("t4_len", t_done - t_acc, 32'd1056);
        check("t4_bytes", {byte0, byte1, byte2, byte3}, 32'hCAFEBEEF);
        check("t4_nack", 32'(nack_err), 32'd0);

`ifdef I2C_CLK_STRETCH_EN
        // T5: slave stretches SCL for 500 clocks after the first ACK
        m_check_en = 1'b0;
        s_stretch = 1'b1;
        s_data = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        pulse_start(t_acc);
        wait_done(3000, t_done);
        repeat (10) @(negedge clk);
        check("t5_stalled", 32'((t_done - t_acc) > 1056 + 400), 32'd1);
        check("t5_bounded", 32'((t_done - t_acc) < 1056 + 520), 32'd1);
        check("t5_bytes", {byte0, byte1, byte2, byte3}, 32'h0F1E2D3C);
        check("t5_nack", 32'(nack_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
